// File: rtl/vx_task_dispatch.sv
// vx_task_dispatch: buffers kernel tasks in a FIFO and deals them round-robin
// to the cores, holding back any core that already has MAX_OUTSTANDING in flight.
module vx_task_dispatch #(
  parameter int NUM_CORES       = 4,
  parameter int TASK_WIDTH      = 64,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PERF_CTR_BITS   = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [TASK_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic [NUM_CORES-1:0]     out_valid,
  output logic [TASK_WIDTH-1:0]    out_data,
  input  logic [NUM_CORES-1:0]     out_ready,
  input  logic [NUM_CORES-1:0]     core_done,
  output logic                     busy,
  output logic [PERF_CTR_BITS-1:0] perf_stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                state;
  logic [TASK_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CRD_W-1:0]      outstanding [NUM_CORES];
  logic [IDX_W-1:0]      target;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_CORES-1:0]  eligible;
  logic [NUM_CORES-1:0]  in_use;
  logic [NUM_CORES-1:0]  credit_inc;
  logic [NUM_CORES-1:0]  credit_dec;
  logic                  sel_found;
  logic                  push;
  logic                  fire;
  logic                  stall;

  // No pass-through: a pop in a full cycle does not open the input that cycle.
  assign in_ready = (count != CNT_W'(DEPTH)) && !reset;
  assign push     = in_valid && in_ready;
  assign fire     = |(out_valid & out_ready);
  assign out_data = mem[rd_ptr];
  assign stall    = (state == IDLE) && (count != '0) && !sel_found;
  assign busy     = (count != '0) || (state == OFFER) || (|in_use);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      if (push && !fire) count <= count + 1'b1;
      else if (fire && !push) count <= count - 1'b1;
    end
  end

  // A done pulse on an idle core is dropped so the credit cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      eligible[i]   = outstanding[i] < CRD_W'(MAX_OUTSTANDING);
      in_use[i]     = outstanding[i] != '0;
      credit_inc[i] = fire && (target == IDX_W'(i));
      credit_dec[i] = core_done[i] && in_use[i];
    end
  end

  // Walk downward so the closest eligible core after rr_ptr is the last write.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (credit_inc[i] && !credit_dec[i]) outstanding[i] <= outstanding[i] + 1'b1;
        else if (credit_dec[i] && !credit_inc[i]) outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      rr_ptr    <= IDX_W'(NUM_CORES - 1);
      out_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && sel_found) begin
            target    <= sel_idx;
            out_valid <= NUM_CORES'(1) << sel_idx;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (fire) begin
            out_valid <= '0;
            rr_ptr    <= target;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_stall_cycles <= '0;
    else if (stall) perf_stall_cycles <= perf_stall_cycles + 1'b1;
  end

  // A completion from a core with nothing in flight points at an upstream bug.
  assert property (@(posedge clk) disable iff (reset) (core_done & ~in_use) == '0);

endmodule

// File: doc/vx_task_dispatch.md
# vx_task_dispatch

Per-cluster task dispatcher sitting directly upstream of each core's distributed-task input. It buffers kernel tasks arriving from the kernel management unit in a FIFO and hands them out to NUM_CORES cores round-robin. It enforces a per-core credit limit on outstanding tasks and reports aggregate busy status and a stall counter.

## Interface
- NUM_CORES, 4: cores served; 1..16.
- TASK_WIDTH, 64: opaque task payload bits.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2: tasks in flight per core; ≥1.
- PERF_CTR_BITS, 44: stall counter width.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream task valid.
- in_data  in  TASK_WIDTH  upstream task payload.
- in_ready  out  1  FIFO can accept.
- out_valid  out  NUM_CORES  one-hot offer to target core.
- out_data  out  TASK_WIDTH  head payload, shared by all cores.
- out_ready  in  NUM_CORES  core accepts.
- core_done  in  NUM_CORES  one-cycle pulse per completed task.
- busy  out  1  work queued, offered, or outstanding.
- perf_stall_cycles  out  PERF_CTR_BITS  cycles blocked on credits.

## Operation
- FIFO: DEPTH entries, registered count. Push when in_valid && in_ready. in_ready = (count != DEPTH) && !reset. No pass-through when full: a pop in the same cycle does not raise in_ready.
- Credits: outstanding[i], width clog2(MAX_OUTSTANDING+1).
  - +1 on fire to core i; −1 on core_done[i]; both in one cycle → unchanged.
  - core_done[i] at 0 is ignored (saturate); simulation assertion fires.
- Eligible core i: outstanding[i] < MAX_OUTSTANDING.
- FSM, two states:
  - IDLE: if count != 0 and any core eligible, select the first eligible core searching from (rr_ptr+1) mod NUM_CORES upward. Register target, go to OFFER.
  - OFFER: out_valid[target]=1 and out_data=FIFO head; both held stable until fire. Fire = out_valid[target] && out_ready[target].
  - On fire: pop FIFO, increment outstanding[target], rr_ptr ← target, return to IDLE.
  - out_valid never depends on out_ready. Readiness of non-target cores is ignored.
- busy = (count != 0) || (state == OFFER) || (any outstanding != 0).
- perf_stall_cycles: +1 each cycle in IDLE with count != 0 and no eligible core. Wraps modulo 2^PERF_CTR_BITS.

## Timing
- Reset values: out_valid=0, busy=0, perf_stall_cycles=0, count=0, all outstanding=0, rr_ptr=NUM_CORES−1 (first grant goes to core 0), state=IDLE. in_ready=0 during reset, 1 on the first cycle after.
- Latency: a task pushed at cycle t into an empty FIFO is visible in IDLE at t+1 and offered (out_valid high) at t+2.
- Throughput: at most one task per 2 cycles, because IDLE always takes a bubble between offers.
- Credit return: core_done at cycle t makes the core eligible for selection at t+1.
- Reset asserted mid-OFFER: out_valid drops the next cycle. The FIFO and credits are cleared with no fire.
- FIFO pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.

## Test plan
- Reset then idle: hold in_valid=0 for 10 cycles → out_valid=0, busy=0, in_ready=1 from the first post-reset cycle, perf_stall_cycles=0.
- Round-robin: NUM_CORES=4, push 4 tasks 0xA0..0xA3 with out_ready all 1 → offered to cores 0,1,2,3 in order with matching payloads. First out_valid appears 2 cycles after the first push; offers are spaced 2 cycles apart.
- Credit stall: MAX_OUTSTANDING=2, 4 cores, push 9 tasks, no core_done → 8 fires (2 per core), and the 9th stays queued with busy=1. perf_stall_cycles increments each cycle. Pulse core_done[2] → the 9th goes to core 2 at +2 cycles.
- Offer hold: target core 1 holds out_ready=0 for 5 cycles while other cores are ready → out_valid=0b0010 and out_data remain stable all 5 cycles. Fire occurs on the cycle ready rises, and no other core is offered.
- FIFO full: DEPTH=8, all out_ready=0, push continuously → in_ready falls after 8 accepts. Hold that state with a pop of the head after out_ready[0]=1 → in_ready rises only the cycle after the pop.
- Simultaneous events and reset: fire to core 0 and core_done[0] in the same cycle → outstanding[0] unchanged. Assert reset mid-OFFER → next cycle out_valid=0, busy=0, count=0.
